// File: rtl/bpm_link_pkg.sv
// Shared definitions for the BPM Aurora link: record layout, default magic
// and the transmit serializer state encoding.
package bpm_link_pkg;

  localparam int BPM_RECORD_WIDTH = 112;
  localparam int HDR_WIDTH        = 16;
  localparam int FIELD_WIDTH      = 32;
  localparam int HDR_LSB          = 96;
  localparam int X_LSB            = 64;
  localparam int Y_LSB            = 32;
  localparam int S_LSB            = 0;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA5BE;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_X,
    SEND_Y,
    SEND_S
  } bpm_tx_state_e;

endpackage

// File: rtl/bpm_record_fifo.sv
// Synchronous record FIFO; read data is combinational from the read pointer,
// so the head record is visible the cycle after it is pushed.
module bpm_record_fifo
  import bpm_link_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = BPM_RECORD_WIDTH,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/write_bpm_link.sv
// BPM Aurora link transmitter: queues 112-bit records and serializes each
// into a 4-word AXI-Stream packet {MAGIC,header}, X, Y, S with statistics.
module write_bpm_link
  import bpm_link_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] MAGIC       = DEFAULT_MAGIC,
  parameter int          COUNT_WIDTH = 16,
  localparam int         LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        auroraUserClk,
  input  logic                        auroraUserReset,
  input  logic                        auroraFAstrobe,
  input  logic                        inhibit,
  input  logic                        counterClear,
  input  logic                        recordStrobe,
  input  logic [BPM_RECORD_WIDTH-1:0] recordData,
  output logic [31:0]                 TX_tdata,
  output logic                        TX_tvalid,
  output logic                        TX_tlast,
  input  logic                        TX_tready,
  output logic [COUNT_WIDTH-1:0]      sessionPacketCount,
  output logic [COUNT_WIDTH-1:0]      txPacketCount,
  output logic [COUNT_WIDTH-1:0]      dropCount,
  output logic [LVL_W-1:0]            fifoLevel,
  output logic                        busy
);

  bpm_tx_state_e               r_state;
  bpm_tx_state_e               w_state_nxt;
  logic [BPM_RECORD_WIDTH-1:0] r_hold;
  logic [BPM_RECORD_WIDTH-1:0] w_fifo_data;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_last_hs;
  logic                        w_pop;
  logic                        w_req;
  logic                        w_push;
  logic                        w_drop;
  logic [COUNT_WIDTH-1:0]      r_tx_cnt;
  logic [COUNT_WIDTH-1:0]      r_drop_cnt;
  logic [COUNT_WIDTH-1:0]      r_sess_cnt;
  logic [COUNT_WIDTH-1:0]      r_sess_out;

  // SEND_S always drives tvalid, so its handshake is just tready.
  assign w_last_hs = (r_state == SEND_S) && TX_tready;
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_last_hs);
  assign w_req     = recordStrobe && !inhibit;
  assign w_push    = w_req && (!w_full || w_pop);
  assign w_drop    = w_req && w_full && !w_pop;

  bpm_record_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BPM_RECORD_WIDTH)
  ) u_fifo (
    .i_clk   (auroraUserClk),
    .i_rst   (auroraUserReset),
    .i_push  (w_push),
    .i_data  (recordData),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifoLevel)
  );

  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) r_state <= IDLE;
    else                 r_state <= w_state_nxt;
  end

  // The holding register only changes on a pop, which keeps tdata stable under backpressure.
  always_ff @(posedge auroraUserClk) begin
    if (w_pop) r_hold <= w_fifo_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    TX_tvalid   = 1'b0;
    TX_tlast    = 1'b0;
    TX_tdata    = '0;
    case (r_state)
      IDLE: begin
        if (w_pop) w_state_nxt = SEND_HDR;
      end
      SEND_HDR: begin
        TX_tvalid = 1'b1;
        TX_tdata  = {MAGIC, r_hold[HDR_LSB +: HDR_WIDTH]};
        if (TX_tready) w_state_nxt = SEND_X;
      end
      SEND_X: begin
        TX_tvalid = 1'b1;
        TX_tdata  = r_hold[X_LSB +: FIELD_WIDTH];
        if (TX_tready) w_state_nxt = SEND_Y;
      end
      SEND_Y: begin
        TX_tvalid = 1'b1;
        TX_tdata  = r_hold[Y_LSB +: FIELD_WIDTH];
        if (TX_tready) w_state_nxt = SEND_S;
      end
      SEND_S: begin
        TX_tvalid = 1'b1;
        TX_tlast  = 1'b1;
        TX_tdata  = r_hold[S_LSB +: FIELD_WIDTH];
        if (TX_tready) w_state_nxt = w_empty ? IDLE : SEND_HDR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_sess_cnt <= '0;
      r_sess_out <= '0;
    end else begin
      if (counterClear)   r_tx_cnt <= '0;
      else if (w_last_hs) r_tx_cnt <= r_tx_cnt + 1'b1;

      if (counterClear) r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != {COUNT_WIDTH{1'b1}}))
        r_drop_cnt <= r_drop_cnt + 1'b1;

      // A packet finishing on the FA strobe belongs to the new session.
      if (auroraFAstrobe) begin
        r_sess_out <= r_sess_cnt;
        r_sess_cnt <= {{(COUNT_WIDTH-1){1'b0}}, w_last_hs};
      end else if (w_last_hs) begin
        r_sess_cnt <= r_sess_cnt + 1'b1;
      end
    end
  end

  assign sessionPacketCount = r_sess_out;
  assign txPacketCount      = r_tx_cnt;
  assign dropCount          = r_drop_cnt;
  assign busy               = (r_state != IDLE);

endmodule

// File: tb/tb_write_bpm_link.sv
// Bench for write_bpm_link: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_write_bpm_link;
  import bpm_link_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst, fa, inhibit, clr, strobe, tready;
  logic [111:0]   data;
  logic [31:0]    tdata;
  logic           tvalid, tlast, busy;
  logic [CW-1:0]  sess_cnt, tx_cnt, drop_cnt;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  write_bpm_link #(
    .FIFO_DEPTH  (DEPTH),
    .MAGIC       (16'hA5BE),
    .COUNT_WIDTH (CW)
  ) dut (
    .auroraUserClk      (clk),
    .auroraUserReset    (rst),
    .auroraFAstrobe     (fa),
    .inhibit            (inhibit),
    .counterClear       (clr),
    .recordStrobe       (strobe),
    .recordData         (data),
    .TX_tdata           (tdata),
    .TX_tvalid          (tvalid),
    .TX_tlast           (tlast),
    .TX_tready          (tready),
    .sessionPacketCount (sess_cnt),
    .txPacketCount      (tx_cnt),
    .dropCount          (drop_cnt),
    .fifoLevel          (level),
    .busy               (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queued records, one record in flight, word index.
  logic [111:0] m_q[$];
  bit           m_busy = 0;
  logic [111:0] m_hold = '0;
  int           m_widx = 0;
  logic [15:0]  m_tx = 0, m_drop = 0, m_sess = 0, m_sess_out = 0;
  bit           chk_en = 0;
  int           cyc = 0;
  bit           mh_hs, mh_lhs, mh_pop, mh_req, mh_room;
  int           mh_sz;

  // Handshaked words as seen on the link.
  logic [31:0]  log_d[$];
  bit           log_l[$];
  int           log_c[$];

  function automatic logic [31:0] word_of(input logic [111:0] r, input int idx);
    case (idx)
      0:       return {16'hA5BE, r[111:96]};
      1:       return r[95:64];
      2:       return r[63:32];
      default: return r[31:0];
    endcase
  endfunction

  function automatic logic [111:0] mk(input logic [15:0] h, input logic [31:0] x,
                                      input logic [31:0] y, input logic [31:0] s);
    return {h, x, y, s};
  endfunction

  function automatic logic [31:0] get_d(input int i);
    return (i < log_d.size()) ? log_d[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int get_c(input int i);
    return (i < log_c.size()) ? log_c[i] : -1;
  endfunction

  function automatic bit get_l(input int i);
    return (i < log_l.size()) ? log_l[i] : 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_widx = 0;
      m_tx = 0; m_drop = 0; m_sess = 0; m_sess_out = 0;
      chk_en = 1;
    end else begin
      mh_sz   = m_q.size();
      mh_hs   = m_busy && tready;
      mh_lhs  = mh_hs && (m_widx == 3);
      mh_pop  = (mh_sz > 0) && (!m_busy || mh_lhs);
      mh_req  = strobe && !inhibit;
      mh_room = (mh_sz < DEPTH) || mh_pop;
      if (mh_pop) begin
        m_hold = m_q.pop_front();
        m_busy = 1; m_widx = 0;
      end else if (mh_lhs) begin
        m_busy = 0;
      end else if (mh_hs) begin
        m_widx++;
      end
      if (mh_req && mh_room) m_q.push_back(data);
      if (clr) m_tx = 0;
      else if (mh_lhs) m_tx++;
      if (clr) m_drop = 0;
      else if (mh_req && !mh_room && m_drop != 16'hFFFF) m_drop++;
      if (fa) begin
        m_sess_out = m_sess;
        m_sess     = mh_lhs ? 16'd1 : 16'd0;
      end else if (mh_lhs) begin
        m_sess++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", tvalid, m_busy);
      check("busy", busy, m_busy);
      if (m_busy) begin
        check("tdata", tdata, word_of(m_hold, m_widx));
        check("tlast", tlast, m_widx == 3);
      end else begin
        check("tlast_idle", tlast, 1'b0);
      end
      check("fifoLevel", level, m_q.size());
      check("txPacketCount", tx_cnt, m_tx);
      check("dropCount", drop_cnt, m_drop);
      check("sessionPacketCount", sess_cnt, m_sess_out);
      if (tvalid && tready) begin
        log_d.push_back(tdata);
        log_l.push_back(tlast);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [111:0] r);
    strobe = 1'b1;
    data   = r;
    tick();
    strobe = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete(); log_l.delete(); log_c.delete();
  endtask

  task automatic pulse_fa();
    fa = 1'b1; tick(); fa = 1'b0;
  endtask

  task automatic check_packet(input string name, input int base, input logic [111:0] r);
    for (int w = 0; w < 4; w++) begin
      check({name, "_word"}, get_d(base + w), word_of(r, w));
      check({name, "_last"}, get_l(base + w), w == 3);
    end
  endtask

  logic [111:0] rec_a, rec_b, rec_c, rec_j;
  logic [111:0] ovf[6];
  logic [127:0] rnd;
  int           k;

  initial begin
    rst = 1'b1; fa = 1'b0; inhibit = 1'b0; clr = 1'b0;
    strobe = 1'b0; tready = 1'b0; data = '0;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx", tx_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_sess", sess_cnt, 0);
    rst = 1'b0;
    tready = 1'b1;
    repeat (2) tick();

    // Single record, ready held high
    rec_a = mk(16'h0005, 32'h11111111, 32'h22222222, 32'h33333333);
    clear_log();
    k = cyc;
    send(rec_a);
    repeat (8) tick();
    check("single_nwords", log_d.size(), 4);
    check("single_w0", get_d(0), 32'hA5BE0005);
    check("single_w1", get_d(1), 32'h11111111);
    check("single_w2", get_d(2), 32'h22222222);
    check("single_w3", get_d(3), 32'h33333333);
    check("single_lasts", {get_l(0), get_l(1), get_l(2), get_l(3)}, 4'b0001);
    check("single_latency", get_c(0), k + 2);
    check("single_contig", get_c(3), k + 5);
    check("single_tx", tx_cnt, 1);

    // Backpressure, ready 1-0-0-1
    rec_b = mk(16'h0A0B, 32'hCAFE0001, 32'hBEEF0002, 32'h12345678);
    clear_log();
    send(rec_b);
    for (int i = 0; i < 24; i++) begin
      tready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    tready = 1'b1;
    repeat (4) tick();
    check("bp_nwords", log_d.size(), 4);
    check_packet("bp", 0, rec_b);
    check("bp_tx", tx_cnt, 2);

    // Overflow with ready low
    clr = 1'b1; tick(); clr = 1'b0;
    tready = 1'b0;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      ovf[i] = mk(16'h0100 + 16'(i), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i));
      send(ovf[i]);
    end
    repeat (3) tick();
    check("ovf_drop", drop_cnt, 1);
    check("ovf_level", level, 4);
    check("ovf_busy", busy, 1'b1);
    tready = 1'b1;
    repeat (30) tick();
    check("ovf_nwords", log_d.size(), 20);
    check("ovf_contig", get_c(19) - get_c(0), 19);
    for (int p = 0; p < 5; p++) check_packet("ovf_pkt", 4 * p, ovf[p]);
    check("ovf_tx", tx_cnt, 5);

    // Inhibit during an in-flight packet
    rec_c = mk(16'h0C0C, 32'hAAAA5555, 32'h5555AAAA, 32'h0F0F0F0F);
    clear_log();
    send(rec_c);
    tick();
    inhibit = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(16'hDEAD, 32'(i), 32'(i), 32'(i)));
    inhibit = 1'b0;
    repeat (10) tick();
    check("inh_drop", drop_cnt, 1);
    check("inh_nwords", log_d.size(), 4);
    check_packet("inh", 0, rec_c);
    check("inh_level", level, 0);
    check("inh_tx", tx_cnt, 6);

    // Session counting
    pulse_fa();
    for (int i = 0; i < 3; i++) send(mk(16'h0300 + 16'(i), 32'(i), 32'(i + 1), 32'(i + 2)));
    repeat (20) tick();
    pulse_fa();
    check("sess_3", sess_cnt, 3);
    for (int i = 0; i < 2; i++) send(mk(16'h0200 + 16'(i), 32'(i), 32'(i + 1), 32'(i + 2)));
    repeat (20) tick();
    pulse_fa();
    check("sess_2", sess_cnt, 2);
    send(mk(16'h0E0E, 32'h1, 32'h2, 32'h3));
    repeat (4) tick();
    pulse_fa();
    check("sess_coinc_old", sess_cnt, 0);
    repeat (3) tick();
    pulse_fa();
    check("sess_coinc_new", sess_cnt, 1);

    // Reset while in SEND_X with records queued
    send(mk(16'h0F01, 32'h1, 32'h2, 32'h3));
    send(mk(16'h0F02, 32'h4, 32'h5, 32'h6));
    send(mk(16'h0F03, 32'h7, 32'h8, 32'h9));
    check("mid_pre_word", tdata, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_tvalid", tvalid, 1'b0);
    check("mid_level", level, 0);
    check("mid_busy", busy, 1'b0);
    check("mid_tx", tx_cnt, 0);
    check("mid_drop", drop_cnt, 0);
    check("mid_sess", sess_cnt, 0);
    rec_j = mk(16'h0777, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98);
    clear_log();
    send(rec_j);
    repeat (8) tick();
    check("mid_nwords", log_d.size(), 4);
    check_packet("mid_after", 0, rec_j);
    check("mid_after_tx", tx_cnt, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd     = {$urandom, $urandom, $urandom, $urandom};
      data    = rnd[111:0];
      strobe  = ($urandom_range(0, 99) < 40);
      inhibit = ($urandom_range(0, 99) < 10);
      tready  = ($urandom_range(0, 99) < 70);
      fa      = ($urandom_range(0, 99) < 3);
      clr     = ($urandom_range(0, 99) < 2);
      tick();
    end
    strobe = 1'b0; inhibit = 1'b0; fa = 1'b0; clr = 1'b0; tready = 1'b1;
    repeat (40) tick();
    check("rand_drained_busy", busy, 1'b0);
    check("rand_drained_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/write_bpm_link.md
Name: write_bpm_link

Overview:
- Transmit end of the BPM Aurora link. Accepts 112-bit BPM records {header[15:0], X[31:0], Y[31:0], S[31:0]} and serializes each into a 4-word, 32-bit AXI-Stream packet on the Aurora TX user interface.
- This is the exact packet format the cell controller's BPM link receivers parse.
- Used in cell-controller-to-cell-controller forwarding and in BPM link emulation for bench/loopback tests.
- Buffers records in a small FIFO, honours TREADY backpressure, and reports per-FA-session and cumulative statistics.

Parameters:
- FIFO_DEPTH, 4: record FIFO depth; must be a power of two, at least 2.
- MAGIC, 16'hA5BE: value placed in bits [31:16] of the header word.
- COUNT_WIDTH, 16: width of the statistics counters.

Ports:
- auroraUserClk  in  1: the only clock; all logic is in the Aurora user clock domain.
- auroraUserReset  in  1: synchronous, active-high reset.
- auroraFAstrobe  in  1: marks the start of an FA transfer session.
- inhibit  in  1: when high, new records are discarded.
- counterClear  in  1: synchronous clear of txPacketCount and dropCount.
- recordStrobe  in  1: recordData is valid this cycle.
- recordData  in  112: {header, X, Y, S}.
- TX_tdata  out  32: AXI-Stream data.
- TX_tvalid  out  1: AXI-Stream valid.
- TX_tlast  out  1: AXI-Stream last.
- TX_tready  in  1: AXI-Stream ready from the Aurora core.
- sessionPacketCount  out  COUNT_WIDTH: packets completed during the previous session.
- txPacketCount  out  COUNT_WIDTH: cumulative packets sent; wraps.
- dropCount  out  COUNT_WIDTH: records dropped on FIFO overflow; saturates.
- fifoLevel  out  clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- busy  out  1: high when the state is not IDLE.

Behaviour:
- Reset values:
  - TX_tvalid=0, TX_tlast=0, TX_tdata=0.
  - All counters 0, fifoLevel 0, busy 0, state IDLE.
  - FIFO is emptied.
  - Reset mid-packet abandons the packet; no tlast is emitted.
- Packet format:
  - Word 0 is {MAGIC, header}.
  - Word 1 is X, word 2 is Y, word 3 is S.
  - TX_tlast=1 only on word 3.
- FIFO write:
  - A write occurs when recordStrobe=1 and inhibit=0 and there is room.
  - Room means fifoLevel<FIFO_DEPTH, or the FIFO is full and a pop happens in the same cycle.
  - If recordStrobe=1, inhibit=0 and there is no room, the record is lost and dropCount increments, saturating at all-ones.
  - Records discarded by inhibit are not counted.
  - inhibit never truncates a packet already in flight or records already queued.
- FIFO pop:
  - A pop occurs in IDLE when the FIFO is non-empty.
  - A pop also occurs in SEND_S when the final word handshakes and the FIFO is non-empty.
  - The popped record loads the holding register.
- States: IDLE, SEND_HDR, SEND_X, SEND_Y, SEND_S.
  - IDLE: on a pop go to SEND_HDR; TX_tvalid becomes 1 on the next cycle.
  - SEND_HDR -> SEND_X, SEND_X -> SEND_Y, SEND_Y -> SEND_S: each advance happens only on TX_tvalid && TX_tready.
  - SEND_S with handshake and FIFO non-empty: go to SEND_HDR with no idle cycle (back-to-back).
  - SEND_S with handshake and FIFO empty: go to IDLE with TX_tvalid=0.
- AXI-Stream rules:
  - While TX_tvalid=1 and TX_tready=0, TX_tdata and TX_tlast hold stable.
  - TX_tvalid never drops mid-packet.
- Latency: a record written at clock edge n with an empty FIFO and state IDLE gives TX_tvalid=1 with word 0 after edge n+2.
  - Throughput is one word per cycle under continuous TX_tready.
- txPacketCount increments on the word-3 handshake and wraps.
- auroraFAstrobe:
  - sessionPacketCount is loaded with the internal session counter, which is then cleared.
  - If a word-3 handshake occurs in the same cycle, it is counted in the new session (session counter loads 1).
- counterClear:
  - Clears txPacketCount and dropCount.
  - An increment in the same cycle is lost; the counter reads 0.
- fifoLevel updates the cycle after a push or pop. A simultaneous push and pop leave it unchanged.

Decomposition:
- Package bpm_link_pkg holds:
  - BPM_RECORD_WIDTH=112.
  - Header, X, Y and S field offsets.
  - Default MAGIC.
  - The state enum (IDLE, SEND_HDR, SEND_X, SEND_Y, SEND_S).
  - This package is shared with the receive path.
- One sub-module: bpm_record_fifo.
  - Synchronous FIFO, FIFO_DEPTH x 112 bits.
  - Signals: push, pop, full, empty, level.
  - First-word data is valid the cycle after push.
- The serializer and counters live in the top module.

Test Plan:
- Single record: header=16'h0005, X=32'h11111111, Y=32'h22222222, S=32'h33333333, TX_tready held at 1 -> TX_tdata = A5BE0005, 11111111, 22222222, 33333333 on four consecutive cycles; tlast only on the last; first valid 2 cycles after the strobe; txPacketCount=1.
- Backpressure: TX_tready toggled in a 1-0-0-1 pattern -> each word held stable while not ready; no duplicated or skipped words; packet completes after 4 handshakes.
- Overflow: TX_tready=0 and 6 consecutive strobes (FIFO_DEPTH=4) -> the first record sits in the holding register, 4 records queue, dropCount=1; releasing TX_tready gives 5 back-to-back packets (20 contiguous valid words).
- Inhibit: inhibit=1 for 3 strobes during a packet -> the in-flight packet completes, the 3 records are discarded, dropCount unchanged.
- Session counting: 3 packets, then auroraFAstrobe, then 2 packets, then auroraFAstrobe -> sessionPacketCount reads 3, then 2; with the strobe coincident with a tlast handshake, that packet counts in the new session.
- Reset mid-packet: auroraUserReset asserted while in SEND_X -> next cycle TX_tvalid=0, fifoLevel=0, counters 0; a subsequent record transmits normally.
